mine_action_ctrl: RTL and testbench

//  Game-action sequencer in front of mine_check. Turns mouse clicks on a board cell into
//  one-cycle flag/bomb requests, waits for the explode/mark_flag/defuse verdict, and keeps
//  per-cell flagged/revealed bitmaps, flag and reveal counters, and the win/lose state.

---
 rtl/mine_action_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mine_action_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mine_action_ctrl.sv
// rtl/mine_action_ctrl.sv - click-to-verdict sequencer for the mine board
// Keeps flagged/revealed bitmaps, flag/reveal counters and the win/lose state; every output is registered.
module mine_action_ctrl #(
  parameter int MINES_EASY   = 10,
  parameter int MINES_MEDIUM = 20,
  parameter int MINES_HARD   = 40,
  parameter int TIMEOUT      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_click,
  input  logic       right_click,
  input  logic [4:0] button_ind_x_in,
  input  logic [4:0] button_ind_y_in,
  input  logic [1:0] level,
  input  logic       explode,
  input  logic       mark_flag,
  input  logic       defuse,
  output logic       flag,
  output logic       bomb,
  output logic       cell_we,
  output logic [4:0] cell_x,
  output logic [4:0] cell_y,
  output logic [1:0] cell_state,
  output logic [7:0] flags_left,
  output logic [7:0] revealed_cnt,
  output logic       busy,
  output logic       game_over,
  output logic       game_won,
  output logic       timeout_err
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, LOST, WON} state_t;

  state_t       state, state_n;
  logic [1:0]   lvl_q, lvl_n;
  logic         op_q, op_n;
  logic [7:0]   wait_cnt, wait_cnt_n;
  logic [255:0] flagged, flagged_n, revealed, revealed_n;
  logic         flag_n, bomb_n, cell_we_n, busy_n, game_over_n, game_won_n, timeout_n;
  logic [4:0]   cell_x_n, cell_y_n, board_n;
  logic [1:0]   cell_state_n;
  logic [7:0]   flags_left_n, revealed_cnt_n;
  logic [7:0]   click_idx, cell_idx;
  logic         click_ok;

  function automatic logic [7:0] mines_of(input logic [1:0] l);
    case (l)
      2'd1:    return 8'(MINES_EASY);
      2'd2:    return 8'(MINES_MEDIUM);
      2'd3:    return 8'(MINES_HARD);
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [4:0] size_of(input logic [1:0] l);
    case (l)
      2'd1:    return 5'd8;
      2'd2:    return 5'd10;
      2'd3:    return 5'd16;
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [7:0] safe_of(input logic [1:0] l);
    case (l)
      2'd1:    return 8'(64 - MINES_EASY);
      2'd2:    return 8'(100 - MINES_MEDIUM);
      2'd3:    return 8'(256 - MINES_HARD);
      default: return 8'd0;
    endcase
  endfunction

  // Bitmap index is column-major: (x-1)*16 + (y-1).
  assign click_idx = {4'(button_ind_x_in - 5'd1), 4'(button_ind_y_in - 5'd1)};
  assign cell_idx  = {4'(cell_x - 5'd1), 4'(cell_y - 5'd1)};
  assign board_n   = size_of(lvl_q);
  assign click_ok  = (lvl_q != 2'd0) && (left_click ^ right_click)
                  && (button_ind_x_in >= 5'd1) && (button_ind_x_in <= board_n)
                  && (button_ind_y_in >= 5'd1) && (button_ind_y_in <= board_n);

  always_comb begin
    state_n        = state;
    lvl_n          = lvl_q;
    op_n           = op_q;
    wait_cnt_n     = wait_cnt;
    flagged_n      = flagged;
    revealed_n     = revealed;
    cell_x_n       = cell_x;
    cell_y_n       = cell_y;
    cell_state_n   = cell_state;
    flags_left_n   = flags_left;
    revealed_cnt_n = revealed_cnt;
    game_over_n    = game_over;
    game_won_n     = game_won;
    timeout_n      = 1'b0;
    if (level != lvl_q) begin
      lvl_n          = level;
      state_n        = IDLE;
      wait_cnt_n     = 8'd0;
      flagged_n      = '0;
      revealed_n     = '0;
      revealed_cnt_n = 8'd0;
      game_over_n    = 1'b0;
      game_won_n     = 1'b0;
      flags_left_n   = mines_of(level);
    end else begin
      case (state)
        IDLE: if (click_ok) begin
          cell_x_n   = button_ind_x_in;
          cell_y_n   = button_ind_y_in;
          op_n       = right_click;
          wait_cnt_n = 8'd0;
          if (left_click) begin
            if (!flagged[click_idx] && !revealed[click_idx]) state_n = ISSUE;
          end else if (flagged[click_idx]) begin
            state_n              = UPDATE;
            cell_state_n         = 2'd0;
            flagged_n[click_idx] = 1'b0;
            flags_left_n         = flags_left + 8'd1;
          end else if (!revealed[click_idx] && (flags_left != 8'd0)) begin
            state_n = ISSUE;
          end
        end
        ISSUE: state_n = WAIT;
        WAIT: begin
          if (!op_q && explode) begin
            state_n      = UPDATE;
            cell_state_n = 2'd3;
          end else if (!op_q && defuse) begin
            state_n              = UPDATE;
            cell_state_n         = 2'd2;
            revealed_n[cell_idx] = 1'b1;
            revealed_cnt_n       = revealed_cnt + 8'd1;
          end else if (op_q && mark_flag) begin
            state_n             = UPDATE;
            cell_state_n        = 2'd1;
            flagged_n[cell_idx] = 1'b1;
            if (flags_left != 8'd0) flags_left_n = flags_left - 8'd1;
          end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
            state_n   = IDLE;
            timeout_n = 1'b1;
          end else begin
            wait_cnt_n = wait_cnt + 8'd1;
          end
        end
        UPDATE: begin
          if (cell_state == 2'd3) begin
            state_n     = LOST;
            game_over_n = 1'b1;
          end else if (revealed_cnt == safe_of(lvl_q)) begin
            state_n    = WON;
            game_won_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        LOST:    state_n = LOST;
        WON:     state_n = WON;
        default: state_n = IDLE;
      endcase
    end
    // Strobes are derived from the state being entered so they line up with it.
    flag_n    = (state_n == ISSUE) && op_n;
    bomb_n    = (state_n == ISSUE) && !op_n;
    cell_we_n = (state_n == UPDATE);
    busy_n    = (state_n == ISSUE) || (state_n == WAIT) || (state_n == UPDATE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lvl_q        <= level;
      op_q         <= 1'b0;
      wait_cnt     <= 8'd0;
      flagged      <= '0;
      revealed     <= '0;
      flag         <= 1'b0;
      bomb         <= 1'b0;
      cell_we      <= 1'b0;
      cell_x       <= 5'd0;
      cell_y       <= 5'd0;
      cell_state   <= 2'd0;
      flags_left   <= mines_of(level);
      revealed_cnt <= 8'd0;
      busy         <= 1'b0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_n;
      lvl_q        <= lvl_n;
      op_q         <= op_n;
      wait_cnt     <= wait_cnt_n;
      flagged      <= flagged_n;
      revealed     <= revealed_n;
      flag         <= flag_n;
      bomb         <= bomb_n;
      cell_we      <= cell_we_n;
      cell_x       <= cell_x_n;
      cell_y       <= cell_y_n;
      cell_state   <= cell_state_n;
      flags_left   <= flags_left_n;
      revealed_cnt <= revealed_cnt_n;
      busy         <= busy_n;
      game_over    <= game_over_n;
      game_won     <= game_won_n;
      timeout_err  <= timeout_n;
    end
  end

endmodule

// File: tb/tb_mine_action_ctrl.sv
// tb/tb_mine_action_ctrl.sv - scoreboard bench for mine_action_ctrl
// The bench plays mine_check from its own mine map and predicts every pulse from a cell-array game model.
module tb_mine_action_ctrl;

  logic       clk = 1'b0;
  logic       rst, left_click, right_click, explode, mark_flag, defuse;
  logic [4:0] button_ind_x_in, button_ind_y_in;
  logic [1:0] level;
  logic       flag, bomb, cell_we, busy, game_over, game_won, timeout_err;
  logic [4:0] cell_x, cell_y;
  logic [1:0] cell_state;
  logic [7:0] flags_left, revealed_cnt;

  always #5 clk = ~clk;

  mine_action_ctrl dut (
    .clk(clk), .rst(rst), .left_click(left_click), .right_click(right_click),
    .button_ind_x_in(button_ind_x_in), .button_ind_y_in(button_ind_y_in), .level(level),
    .explode(explode), .mark_flag(mark_flag), .defuse(defuse),
    .flag(flag), .bomb(bomb), .cell_we(cell_we), .cell_x(cell_x), .cell_y(cell_y),
    .cell_state(cell_state), .flags_left(flags_left), .revealed_cnt(revealed_cnt),
    .busy(busy), .game_over(game_over), .game_won(game_won), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [3:0] kind;
    int cyc;
    int x;
    int y;
    int st;
    int fl;
    int rc;
  } exp_t;

  localparam logic [3:0] K_FLAG = 4'b1000, K_BOMB = 4'b0100, K_WE = 4'b0010, K_TOUT = 4'b0001;

  exp_t exp_q[$];
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  bit mine_m [0:31][0:31];
  bit flag_m [0:31][0:31];
  bit rev_m  [0:31][0:31];
  int m_level, m_n, m_mines, m_fl, m_rc;
  bit m_over, m_won;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] kind, input int cy, input int x, input int y, input int st);
    exp_t e;
    e.kind = kind; e.cyc = cy; e.x = x; e.y = y; e.st = st; e.fl = m_fl; e.rc = m_rc;
    exp_q.push_back(e);
  endtask

  task automatic model_reset(input int l);
    int placed, x, y;
    m_level = l;
    m_n     = (l == 1) ? 8 : (l == 2) ? 10 : (l == 3) ? 16 : 0;
    m_mines = (l == 1) ? 10 : (l == 2) ? 20 : (l == 3) ? 40 : 0;
    m_fl = m_mines; m_rc = 0; m_over = 0; m_won = 0;
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) begin
        mine_m[i][j] = 0; flag_m[i][j] = 0; rev_m[i][j] = 0;
      end
    placed = 0;
    while (placed < m_mines) begin
      x = $urandom_range(1, m_n);
      y = $urandom_range(1, m_n);
      if (!mine_m[x][y]) begin
        mine_m[x][y] = 1;
        placed++;
      end
    end
  endtask

  task automatic end_checks();
    check("flags_left", flags_left, m_fl);
    check("revealed_cnt", revealed_cnt, m_rc);
    check("game_over", game_over, m_over);
    check("game_won", game_won, m_won);
    check("busy_idle", busy, 0);
  endtask

  task automatic set_level(input int l);
    level = 2'(l);
    step();
    step();
    model_reset(l);
    end_checks();
  endtask

  // One click: predict from the game rules, answer as mine_check, and wait until the DUT settles.
  task automatic do_click(input bit l, input bit r, input int x, input int y,
                          input bit tmo, input int d, input bit junk, input bit inject);
    int c, act, endc, vcyc, k, st;
    bit on;
    c = cyc;
    on = (m_level != 0) && (x >= 1) && (x <= m_n) && (y >= 1) && (y <= m_n);
    act = 0;
    if (on && (l != r) && !m_over && !m_won) begin
      if (l) begin
        if (!flag_m[x][y] && !rev_m[x][y]) act = 2;
      end else if (flag_m[x][y]) act = 1;
      else if (!rev_m[x][y] && m_fl > 0) act = 3;
    end
    endc = c + 1;
    vcyc = -1;
    if (act == 1) begin
      flag_m[x][y] = 0;
      m_fl++;
      push_exp(K_WE, c + 1, x, y, 0);
      endc = c + 2;
    end else if (act >= 2) begin
      push_exp((act == 2) ? K_BOMB : K_FLAG, c + 1, x, y, 0);
      if (tmo) begin
        push_exp(K_TOUT, c + 6, x, y, 0);
        endc = c + 6;
      end else begin
        vcyc = c + 2 + d;
        if (act == 3) begin
          st = 1; flag_m[x][y] = 1; m_fl--;
        end else if (mine_m[x][y]) begin
          st = 3; m_over = 1;
        end else begin
          st = 2; rev_m[x][y] = 1; m_rc++;
          if (m_rc == m_n * m_n - m_mines) m_won = 1;
        end
        push_exp(K_WE, vcyc + 1, x, y, st);
        endc = vcyc + 2;
      end
    end
    left_click = l; right_click = r;
    button_ind_x_in = 5'(x); button_ind_y_in = 5'(y);
    step();
    left_click = 0; right_click = 0;
    while (cyc < endc) begin
      k = cyc;
      if (k == c + 2 && act >= 2) check("busy_wait", busy, 1);
      if (k == vcyc) begin
        if (act == 3) mark_flag = 1;
        else if (mine_m[x][y]) explode = 1;
        else defuse = 1;
      end else if (junk && k == c + 2) begin
        if (act == 3) begin explode = 1; defuse = 1; end
        else mark_flag = 1;
      end
      if (inject && k == c + 2) begin
        left_click = 1; button_ind_x_in = 5'd1; button_ind_y_in = 5'd2;
      end
      step();
      explode = 0; mark_flag = 0; defuse = 0; left_click = 0;
    end
    end_checks();
  endtask

  logic [3:0] mon_kind;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_kind = {flag, bomb, cell_we, timeout_err};
      if (mon_kind != 4'd0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: got kind %b, expected none at cycle %0d", mon_kind, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", mon_kind, mon_e.kind);
          check("pulse_cycle", cyc, mon_e.cyc);
          if (mon_e.kind == K_WE) begin
            check("cell_x", cell_x, mon_e.x);
            check("cell_y", cell_y, mon_e.y);
            check("cell_state", cell_state, mon_e.st);
            check("we_flags_left", flags_left, mon_e.fl);
            check("we_revealed_cnt", revealed_cnt, mon_e.rc);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int c0, r, x, y, d, nl;
    bit tmo, junk, inj, lc, rc;
    rst = 1; level = 2'd1; left_click = 0; right_click = 0;
    button_ind_x_in = 0; button_ind_y_in = 0; explode = 0; mark_flag = 0; defuse = 0;
    model_reset(1);
    repeat (3) step();
    check("rst_flags_left", flags_left, 10);
    check("rst_flag", flag, 0);
    check("rst_bomb", bomb, 0);
    check("rst_cell_we", cell_we, 0);
    check("rst_cell_x", cell_x, 0);
    check("rst_cell_y", cell_y, 0);
    check("rst_cell_state", cell_state, 0);
    check("rst_revealed_cnt", revealed_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_game_over", game_over, 0);
    check("rst_game_won", game_won, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 0;
    step();

    mine_m[3][4] = 0; mine_m[1][1] = 0; mine_m[5][5] = 1;
    do_click(1, 0, 3, 4, 0, 0, 0, 0);
    do_click(0, 1, 1, 1, 0, 0, 0, 0);
    do_click(0, 1, 1, 1, 0, 0, 0, 0);
    do_click(1, 0, 5, 5, 0, 0, 0, 0);
    check("lost_game_over", game_over, 1);
    do_click(1, 0, 2, 2, 0, 0, 0, 0);
    set_level(2);
    check("lvl2_flags_left", flags_left, 20);

    mine_m[2][3] = 0;
    do_click(1, 0, 2, 3, 1, 0, 0, 1);
    do_click(1, 0, 2, 3, 0, 2, 1, 0);
    do_click(0, 1, 4, 4, 0, 3, 1, 1);

    mine_m[6][6] = 0;
    c0 = cyc;
    push_exp(K_BOMB, c0 + 1, 6, 6, 0);
    left_click = 1; button_ind_x_in = 5'd6; button_ind_y_in = 5'd6;
    step();
    left_click = 0;
    step();
    check("abort_busy", busy, 1);
    level = 2'd3; defuse = 1;
    step();
    defuse = 0;
    step();
    model_reset(3);
    end_checks();

    set_level(1);
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 32; j++) mine_m[i][j] = 0;
    for (int j = 1; j <= 8; j++) mine_m[8][j] = 1;
    mine_m[7][1] = 1; mine_m[7][2] = 1;
    do_click(1, 0, 9, 1, 0, 0, 0, 0);
    do_click(0, 1, 0, 3, 0, 0, 0, 0);
    do_click(1, 1, 2, 2, 0, 0, 0, 0);
    do_click(1, 0, 3, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      for (int j = 1; j <= 8; j++)
        if (mine_m[i][j]) do_click(0, 1, i, j, 0, 0, 0, 0);
    check("flags_exhausted", flags_left, 0);
    do_click(0, 1, 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++)
      for (int j = 1; j <= 8; j++)
        if (!mine_m[i][j]) do_click(1, 0, i, j, 0, 0, 0, 0);
    check("win_game_won", game_won, 1);
    check("win_revealed_cnt", revealed_cnt, 54);
    do_click(1, 0, 8, 8, 0, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if (m_over || m_won || $urandom_range(0, 59) == 0) begin
        do nl = $urandom_range(1, 3); while (nl == m_level);
        set_level(nl);
      end
      r  = $urandom_range(0, 9);
      lc = (r <= 6);
      rc = (r >= 7) || (r == 0);
      x  = $urandom_range(0, m_n + 1);
      y  = $urandom_range(0, m_n + 1);
      tmo  = ($urandom_range(0, 9) == 0);
      d    = $urandom_range(0, 3);
      junk = ($urandom_range(0, 3) == 0);
      inj  = ($urandom_range(0, 4) == 0);
      do_click(lc, rc, x, y, tmo, d, junk, inj);
    end

    repeat (5) step();
    check("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
